instr_fetch: RTL and testbench

- Fetch stage of the 16-bit lab CPU. Sits directly upstream of the synchronous instruction ROM (1-cycle read latency, read on `en`).
- Owns the PC, issues ROM reads and absorbs the ROM latency in a 2-entry buffer.
- Delivers {instruction, pc} pairs to decode over a valid/ready handshake.
- Accepts PC redirects from execute (jump) and flushes any wrong-path fetches.

---
 rtl/instr_fetch.sv | 106 ++++++++++
 tb/tb_instr_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues synchronous ROM reads and buffers returned
// words in a 2-entry FIFO that feeds decode over a valid/ready handshake.
module instr_fetch #(
  parameter int unsigned       AWIDTH   = 16,
  parameter int unsigned       DWIDTH   = 16,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_en,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_dout,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_instr,
  output logic [AWIDTH-1:0] out_pc
);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [AWIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]        count_q, count_d;
  // Slot 0 is always the head; slot 1 only holds data when count is 2.
  logic [DWIDTH-1:0] instr_q [2];
  logic [DWIDTH-1:0] instr_d [2];
  logic [AWIDTH-1:0] epc_q [2];
  logic [AWIDTH-1:0] epc_d [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;

  always_comb begin
    pop   = (count_q != 2'd0) & out_ready;
    push  = inflight_q;
    occ   = {1'b0, count_q} + {2'b00, inflight_q};
    // Occupancy counts both buffered and outstanding words, so the FIFO never overflows.
    issue = !rst & !redirect_valid & ((occ - {2'b00, pop}) < 3'd2);

    pc_d          = issue ? pc_q + AWIDTH'(1) : pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    instr_d       = instr_q;
    epc_d         = epc_q;
    count_d       = count_q - {1'b0, pop} + {1'b0, push};

    if (pop) begin
      if (count_q == 2'd2) begin
        instr_d[0] = instr_q[1];
        epc_d[0]   = epc_q[1];
        if (push) begin
          instr_d[1] = rom_dout;
          epc_d[1]   = inflight_pc_q;
        end
      end else if (push) begin
        instr_d[0] = rom_dout;
        epc_d[0]   = inflight_pc_q;
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        instr_d[0] = rom_dout;
        epc_d[0]   = inflight_pc_q;
      end else begin
        instr_d[1] = rom_dout;
        epc_d[1]   = inflight_pc_q;
      end
    end

    // Flush: any returning word and buffered entries belong to the wrong path.
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      count_d    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      instr_q[0]    <= '0;
      epc_q[0]      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      instr_q[0]    <= instr_d[0];
      epc_q[0]      <= epc_d[0];
    end
    instr_q[1] <= instr_d[1];
    epc_q[1]   <= epc_d[1];
  end

  assign rom_en    = issue;
  assign rom_addr  = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = instr_q[0];
  assign out_pc    = epc_q[0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model of the fetch pipeline checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [15:0] rom_dout;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  logic        w_rom_en;
  logic [15:0] w_rom_addr;
  logic [15:0] w_rom_dout;
  logic        w_out_valid;
  logic [15:0] w_out_instr;
  logic [15:0] w_out_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {logic [15:0] pc; int cyc;} item_t;
  typedef struct {logic [15:0] pc; logic [15:0] instr; int cyc;} pop_t;

  item_t       mq[$];
  pop_t        plog[$];
  pop_t        wlog[$];
  logic [15:0] fetch_pc;
  bit          model_on = 0;

  instr_fetch #(.AWIDTH(16), .DWIDTH(16), .RESET_PC(16'h0000)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  instr_fetch #(.AWIDTH(16), .DWIDTH(16), .RESET_PC(16'hFFFE)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .rom_en         (w_rom_en),
    .rom_addr       (w_rom_addr),
    .rom_dout       (w_rom_dout),
    .redirect_valid (1'b0),
    .redirect_pc    (16'h0000),
    .out_valid      (w_out_valid),
    .out_ready      (1'b1),
    .out_instr      (w_out_instr),
    .out_pc         (w_out_pc)
  );

  function automatic logic [15:0] mem(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h0004;
      16'd1:   return 16'h2400;
      16'd2:   return 16'h3400;
      16'd3:   return 16'h6400;
      16'd4:   return 16'h4000;
      16'd5:   return 16'h5400;
      16'd6:   return 16'hD201;
      16'd7:   return 16'hC001;
      16'd8:   return 16'h7000;
      default: return a ^ 16'hA5A5;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROMs, one-cycle latency
  always @(posedge clk) if (rom_en) rom_dout <= mem(rom_addr);
  always @(posedge clk) if (w_rom_en) w_rom_dout <= mem(w_rom_addr);

  // Model: every issued address is delivered, in order, exactly two cycles after issue
  // at the earliest; a flush discards everything issued but not yet delivered.
  always @(negedge clk) begin : model
    bit ev;
    bit pop;
    bit iss;
    ev  = 1'b0;
    pop = 1'b0;
    if (model_on) begin
      ev = (mq.size() > 0) && (mq[0].cyc + 2 <= cyc);
      check("out_valid", {31'd0, out_valid}, {31'd0, ev});
      if (ev) begin
        check("out_pc", {16'd0, out_pc}, {16'd0, mq[0].pc});
        check("out_instr", {16'd0, out_instr}, {16'd0, mem(mq[0].pc)});
      end
      if (out_valid && out_ready) plog.push_back('{out_pc, out_instr, cyc});
      if (w_out_valid) wlog.push_back('{w_out_pc, w_out_instr, cyc});
      pop = ev && out_ready;
    end
    iss = !rst && !redirect_valid && (mq.size() - int'(pop) < 2);
    check("rom_en", {31'd0, rom_en}, {31'd0, iss});
    if (iss) check("rom_addr", {16'd0, rom_addr}, {16'd0, fetch_pc});

    if (rst) begin
      mq.delete();
      fetch_pc = 16'h0000;
      model_on = 1'b1;
    end else if (redirect_valid) begin
      mq.delete();
      fetch_pc = redirect_pc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (iss) begin
        mq.push_back('{fetch_pc, cyc});
        fetch_pc = fetch_pc + 16'd1;
      end
    end
  end

  initial begin
    int n;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    out_ready      = 1'b1;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", {16'd0, out_pc}, 32'd0);
    check("rst_out_instr", {16'd0, out_instr}, 32'd0);
    check("rst_rom_en", {31'd0, rom_en}, 32'd0);
    rst = 1'b0;
    #1;
    check("first_rom_en", {31'd0, rom_en}, 32'd1);
    check("first_rom_addr", {16'd0, rom_addr}, 32'd0);
    tick();
    tick();
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_pc", {16'd0, out_pc}, 32'd0);
    check("first_instr", {16'd0, out_instr}, 32'h0004);

    // Stream to pc 3, then stall for five cycles
    repeat (3) tick();
    check("pre_stall_pc", {16'd0, out_pc}, 32'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_pc", {16'd0, out_pc}, 32'd3);
      check("stall_rom_en", {31'd0, rom_en}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    repeat (5) tick();
    check("pre_redirect_pc", {16'd0, out_pc}, 32'd8);
    check("pre_redirect_issue", {31'd0, rom_en}, 32'd1);

    // Redirect back to 0 while 9 is in flight
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    #1;
    check("redirect_rom_en", {31'd0, rom_en}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("post_redirect_valid", {31'd0, out_valid}, 32'd0);
    #1;
    check("refetch_rom_en", {31'd0, rom_en}, 32'd1);
    check("refetch_rom_addr", {16'd0, rom_addr}, 32'd0);
    tick();
    tick();
    check("refetch_valid", {31'd0, out_valid}, 32'd1);
    check("refetch_pc", {16'd0, out_pc}, 32'd0);
    check("refetch_instr", {16'd0, out_instr}, 32'h0004);

    // Fill the FIFO, then reset mid-stream
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    tick();
    check("full_rom_en", {31'd0, rom_en}, 32'd0);
    n = plog.size();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    #1;
    check("midrst_rom_en", {31'd0, rom_en}, 32'd1);
    check("midrst_rom_addr", {16'd0, rom_addr}, 32'd0);
    out_ready = 1'b1;
    repeat (6) tick();

    // Delivered-stream checks
    check("log_len", {31'd0, plog.size() > n}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      check("stream_pc", {16'd0, plog[i].pc}, i);
      check("stream_instr", {16'd0, plog[i].instr}, {16'd0, mem(16'(i))});
    end
    for (int i = 0; i < 8; i++)
      check("stream_gap", plog[i+1].cyc - plog[i].cyc, (i == 2) ? 32'd6 : 32'd1);
    check("redirect_next_pc", {16'd0, plog[9].pc}, 32'd0);
    check("redirect_next_instr", {16'd0, plog[9].instr}, 32'h0004);
    check("redirect_gap", plog[9].cyc - plog[8].cyc, 32'd3);
    check("midrst_next_pc", {16'd0, plog[n].pc}, 32'd0);
    check("midrst_next_instr", {16'd0, plog[n].instr}, 32'h0004);

    check("wrap_len", {31'd0, wlog.size() >= 3}, 32'd1);
    if (wlog.size() >= 3) begin
      check("wrap_pc0", {16'd0, wlog[0].pc}, 32'hFFFE);
      check("wrap_instr0", {16'd0, wlog[0].instr}, 32'h5A5B);
      check("wrap_pc1", {16'd0, wlog[1].pc}, 32'hFFFF);
      check("wrap_instr1", {16'd0, wlog[1].instr}, 32'h5A5A);
      check("wrap_pc2", {16'd0, wlog[2].pc}, 32'h0000);
      check("wrap_instr2", {16'd0, wlog[2].instr}, 32'h0004);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
